// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam int unsigned ITERATIONS = 32;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling: operand magnitudes on entry, conditional negation of the result in FIX.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        is_signed,
  output logic [31:0] abs_a,
  output logic [31:0] abs_b,
  input  logic        mul_mode,
  input  logic        neg_hi,
  input  logic        neg_lo,
  input  logic [31:0] in_hi,
  input  logic [31:0] in_lo,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
);

  logic [63:0] prod_neg;

  always_comb begin
    abs_a = (is_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    abs_b = (is_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
  end

  assign prod_neg = ~{in_hi, in_lo} + 64'd1;

  // Multiply negates the full 64-bit product; divide negates quotient and remainder separately.
  always_comb begin
    out_hi = in_hi;
    out_lo = in_lo;
    if (mul_mode) begin
      if (neg_lo) begin
        out_hi = prod_neg[63:32];
        out_lo = prod_neg[31:0];
      end
    end else begin
      if (neg_hi) out_hi = ~in_hi + 32'd1;
      if (neg_lo) out_lo = ~in_lo + 32'd1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        abort,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state, state_nx;
  op_e         op_in, op_q;
  logic [4:0]  cnt;
  logic [31:0] mcd_q;
  logic [31:0] acc_q;
  logic [31:0] shr_q;
  logic [31:0] raw_a_q;
  logic        neg_hi_q, neg_lo_q, dz_q;

  logic        launch, signed_in, is_div_in, dz_in, sgn_x;
  logic [31:0] abs_a, abs_b, fix_hi, fix_lo;
  logic [32:0] add_sum, div_shift, div_diff;

  assign op_in     = op_e'(op);
  assign launch    = (state == ST_IDLE) && start && !abort;
  assign signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign is_div_in = op_in[1];
  assign dz_in     = is_div_in && (src_b == '0);
  assign sgn_x     = src_a[31] ^ src_b[31];

  muldiv_signfix u_signfix (
    .src_a     (src_a),
    .src_b     (src_b),
    .is_signed (signed_in),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .mul_mode  (!op_q[1]),
    .neg_hi    (neg_hi_q),
    .neg_lo    (neg_lo_q),
    .in_hi     (acc_q),
    .in_lo     (shr_q),
    .out_hi    (fix_hi),
    .out_lo    (fix_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (launch) state_nx = dz_in ? ST_FIX : ST_CALC;
      ST_CALC: begin
        if (abort)                               state_nx = ST_IDLE;
        else if (cnt == 5'(ITERATIONS - 1))      state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Multiply keeps {acc, shr} as the shifting product; divide shifts the dividend out of shr into acc.
  assign add_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, mcd_q} : 33'd0);
  assign div_shift = {acc_q, shr_q[31]};
  assign div_diff  = div_shift - {1'b0, mcd_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_MULT;
      cnt      <= '0;
      mcd_q    <= '0;
      acc_q    <= '0;
      shr_q    <= '0;
      raw_a_q  <= '0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (launch) begin
      op_q     <= op_in;
      cnt      <= '0;
      acc_q    <= '0;
      raw_a_q  <= src_a;
      mcd_q    <= is_div_in ? abs_b : abs_a;
      shr_q    <= is_div_in ? abs_a : abs_b;
      neg_lo_q <= signed_in && sgn_x;
      neg_hi_q <= (op_in == OP_DIV) && src_a[31];
      dz_q     <= dz_in;
    end else if (state == ST_CALC && !abort) begin
      cnt <= cnt + 5'd1;
      if (!op_q[1]) begin
        acc_q <= add_sum[32:1];
        shr_q <= {add_sum[0], shr_q[31:1]};
      end else if (!div_diff[32]) begin
        acc_q <= div_diff[31:0];
        shr_q <= {shr_q[30:0], 1'b1};
      end else begin
        acc_q <= div_shift[31:0];
        shr_q <= {shr_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_FIX) && !abort;
      if (state == ST_FIX && !abort) begin
        hi <= dz_q ? raw_a_q   : fix_hi;
        lo <= dz_q ? DIV0_QUOT : fix_lo;
      end else if (state == ST_IDLE) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        abort;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  ex_muldiv dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .abort   (abort),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; launches one operation and follows it to completion.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat, input bit wr_both, input bit poke);
    int lat;
    int busy_n;
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (wr_both) begin
      wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h55;
    end
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    src_a = $urandom; src_b = $urandom;
    if (wr_both) begin
      chk({tag, "_wrhi"}, hi, 32'h55);
      chk({tag, "_wrlo"}, lo, 32'h55);
    end
    lat = 0;
    busy_n = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      if (poke && lat == 5) begin
        start = 1'b1; op = 2'b11; src_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busycyc"}, busy_n, elat);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_busy"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, "_donepulse"}, done, 1'b0);
  endtask

  initial begin
    int dn;
    reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    abort = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 0, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0, 1);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, 0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 33, 0, 0);
    run_op("divu",      2'b11, 32'h1234_5678, 32'd100,      32'h60,        32'h002E_9A76, 33, 0, 0);
    run_op("div_m100",  2'b10, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFF2, 33, 0, 0);
    run_op("mult_big",  2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 33, 0, 0);
    run_op("divu_zero", 2'b11, 32'd7,         32'd0,        32'h7,         32'hFFFF_FFFF,  1, 1, 0);
    run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF,  1, 0, 0);

    // abort beats start in IDLE
    op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abstart_busy", busy, 1'b0);
    chk("abstart_hi", hi, 32'hFFFF_FFFB);

    // preload, then abort an in-flight MULT
    wr_hi = 1'b1; wr_data = 32'h11;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h22;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("pre_hi", hi, 32'h11);
    chk("pre_lo", lo, 32'h22);
    op = 2'b00; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      wr_hi = (k == 5); wr_data = 32'h99;
      @(negedge clk);
    end
    wr_hi = 1'b0;
    chk("busy_wr_hi", hi, 32'h11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hi", hi, 32'h11);
    chk("abort_lo", lo, 32'h22);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort_nodone", dn, 0);
    chk("abort_hi_late", hi, 32'h11);

    // reset in the middle of an operation
    op = 2'b00; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("mrst_nodone", dn, 0);
    chk("mrst_busy_late", busy, 1'b0);
    run_op("multu_post", 2'b01, 32'd3, 32'd5, 32'h0, 32'hF, 33, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-003 SHALL have port: start  input  1  launch an operation; sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: src_a  input  32  multiplicand or dividend, from the EX operand mux.
REQ-006 SHALL have port: src_b  input  32  multiplier or divisor.
REQ-007 SHALL have port: abort  input  1  EX flush; cancels any in-flight operation.
REQ-008 SHALL have ports: wr_hi and wr_lo  input  1 each  MTHI/MTLO strobes.
REQ-009 SHALL have port: wr_data  input  32  data for wr_hi/wr_lo.
REQ-010 SHALL have port: busy  output  1  high whenever the FSM is not IDLE; feeds the hazard unit as a stall request.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when HI/LO update from a completed operation.
REQ-012 SHALL have ports: hi and lo  output  32 each  architectural HI/LO registers; read by MFHI/MFLO.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and FIX; busy is decoded from the registered state.
REQ-014 In IDLE with start=1 and abort=0, SHALL latch operands and op, latch magnitudes for signed ops, clear a 5-bit iteration counter and go to CALC.
REQ-015 In that IDLE case, if op is DIV or DIVU and src_b=0, SHALL go directly to FIX instead of CALC.
REQ-016 CALC SHALL perform one radix-2 iteration per cycle (shift-add for multiply, restoring subtract for divide) on unsigned 32-bit magnitudes.
REQ-017 CALC SHALL go to FIX on the edge that completes iteration 32 (counter wraps 31 -> 0).
REQ-018 FIX SHALL apply sign correction, write HI/LO, and return to IDLE on the next edge.
REQ-019 done SHALL be registered and high for exactly the one cycle in which the new HI/LO are first visible.
REQ-020 Latency: start sampled at edge N; HI/LO, done=1 and busy=0 all appear after edge N+33.
REQ-021 Latency, divide-by-zero: the same appear after edge N+1.
REQ-022 Multiply: {hi,lo} SHALL equal the 64-bit product; for MULT, negate the 64-bit magnitude product when src_a[31]^src_b[31].
REQ-023 Divide: lo=quotient, hi=remainder; for DIV, quotient sign = src_a[31]^src_b[31] and remainder sign = src_a[31].
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0 (natural 32-bit wrap, no trap).
REQ-025 Division by zero SHALL yield hi=src_a and lo=0xFFFFFFFF, for both DIV and DIVU.
REQ-026 start while busy SHALL be ignored, and the in-flight operation continues.
REQ-027 abort=1 in CALC or FIX SHALL force IDLE on the next edge, with hi/lo unchanged and no done.
REQ-028 abort=1 together with start in IDLE: abort wins and no operation launches.
REQ-029 wr_hi/wr_lo SHALL update hi/lo on the next edge only when in IDLE, and are ignored when busy.
REQ-030 wr_hi/wr_lo in the same IDLE cycle as start SHALL take effect, and the launched operation later overwrites both hi and lo.

Reset
REQ-031 On reset=0, asynchronously: state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, internal operand and partial registers=0.
REQ-032 Reset asserted mid-operation SHALL discard the operation; no done pulse after reset is released.
REQ-033 The first start SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-034 Shared package muldiv_pkg SHALL hold: the op encodings, the FSM state encoding, ITERATIONS=32, and the divide-by-zero quotient constant 0xFFFFFFFF.
REQ-035 One combinational sub-module, muldiv_signfix, SHALL compute absolute values on entry and conditional two's-complement negation in FIX.
REQ-036 All other logic (FSM, counter, iteration datapath, HI/LO) SHALL reside in ex_muldiv.

Verification
REQ-037 MULT src_a=0xFFFFFFFD, src_b=7 -> after 33 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
REQ-038 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-039 DIV 0xFFFFFFF9 by 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 DIVU 7 by 0 -> after 1 cycle: hi=7, lo=0xFFFFFFFF, done=1.
REQ-042 Preload hi=0x11, lo=0x22; start MULT; assert abort at cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done.
REQ-043 Start MULT; drive reset=0 mid-operation -> all outputs 0 immediately, with no stray done after release.
